// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC sequencer.
//   seq_state_e : sequencer FSM states
//   idx_w       : index width for n items, never less than 1
//   next_chan   : round-robin pick of the next set mask bit after ptr, wrapping
package adc_seq_pkg;

   localparam int MAXCH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SAMP,
      ST_COMP,
      ST_UPD,
      ST_CAPT,
      ST_OUT
   } seq_state_e;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Returns ptr unchanged when mask is empty; callers never use the pick then.
   function automatic int next_chan(input logic [MAXCH-1:0] mask, input int ptr, input int n);
      int   c;
      logic found;
      next_chan = ptr;
      found     = 1'b0;
      for (int i = 1; i <= MAXCH; i++) begin
         c = ptr + i;
         if (c >= n) c = c - n;
         if (!found && i <= n) begin
            if (mask[c[4:0]]) begin
               next_chan = c;
               found     = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/adc_seq_rr.sv
// Round-robin channel picker.
//   clk, rst : clock, synchronous active-high reset
//   mask     : enabled channels
//   load     : commit the current pick as the new pointer
//   pick     : next enabled channel after the pointer (combinational)
// The pointer resets to Nch-1 so the first pick is the lowest set mask bit.
module adc_seq_rr
   import adc_seq_pkg::*;
#(
   parameter  int Nch = 4,
   localparam int CW  = idx_w(Nch)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [Nch-1:0] mask,
   input  logic          load,
   output logic [CW-1:0] pick
);

   logic [CW-1:0] ptr;

   assign pick = CW'(next_chan(MAXCH'(mask), int'(ptr), Nch));

   always_ff @(posedge clk) begin
      if (rst)       ptr <= CW'(Nch - 1);
      else if (load) ptr <= pick;
   end

endmodule

// File: rtl/adc_seqctrl.sv
// SAR ADC sequencer and result collector.
//   clk, rst            : clock, synchronous active-high reset
//   start, cont         : single-shot request, continuous mode
//   ch_mask             : enabled slices, served round-robin
//   samp_cycles         : sampling length (0 treated as 1), latched at INIT
//   comp_out            : comparator decision per slice
//   seq_init/samp/comp/update : phase strobes
//   ch_en               : one-hot active slice, INIT through CAPT
//   busy                : conversion in progress
//   res_data/chan/valid, res_ready : result handoff, first decision in MSB
//
// state | meaning
// IDLE  | waiting for start or cont with a non-empty mask
// INIT  | 1 cycle, channel picked, seq_init
// SAMP  | max(samp_cycles,1) cycles, seq_samp
// COMP  | 1 cycle, seq_comp (decision k)
// UPD   | 1 cycle, seq_update, decision k captured
// CAPT  | last decision captured, no strobes
// OUT   | res_valid held until res_ready
module adc_seqctrl
   import adc_seq_pkg::*;
#(
   parameter  int Madc  = 17,
   parameter  int Nch   = 4,
   parameter  int SAMPW = 8,
   localparam int CW    = idx_w(Nch)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic [Nch-1:0]   ch_mask,
   input  logic [SAMPW-1:0] samp_cycles,
   input  logic [Nch-1:0]   comp_out,
   output logic             seq_init,
   output logic             seq_samp,
   output logic             seq_comp,
   output logic             seq_update,
   output logic [Nch-1:0]   ch_en,
   output logic             busy,
   output logic [Madc-1:0]  res_data,
   output logic [CW-1:0]    res_chan,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam int KW = idx_w(Madc);

   seq_state_e       state, state_nxt;
   logic [SAMPW-1:0] samp_lat, samp_cnt;
   logic [KW-1:0]    bit_cnt;
   logic [Madc-1:0]  sr;
   logic [CW-1:0]    ch_idx, pick;
   logic             pick_load;
   logic             cur_bit;

   assign cur_bit   = comp_out[ch_idx];
   assign pick_load = (state_nxt == ST_INIT);

   adc_seq_rr #(.Nch(Nch)) u_rr (
      .clk  (clk),
      .rst  (rst),
      .mask (ch_mask),
      .load (pick_load),
      .pick (pick)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if ((start || cont) && (|ch_mask)) state_nxt = ST_INIT;
         ST_INIT: state_nxt = ST_SAMP;
         ST_SAMP: if (samp_cnt == '0) state_nxt = ST_COMP;
         ST_COMP: state_nxt = (bit_cnt == KW'(Madc - 1)) ? ST_CAPT : ST_UPD;
         ST_UPD:  state_nxt = ST_COMP;
         ST_CAPT: state_nxt = ST_OUT;
         ST_OUT:  if (res_ready) state_nxt = (cont && (|ch_mask)) ? ST_INIT : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         seq_init   <= 1'b0;
         seq_samp   <= 1'b0;
         seq_comp   <= 1'b0;
         seq_update <= 1'b0;
         busy       <= 1'b0;
         res_valid  <= 1'b0;
         ch_en      <= '0;
         ch_idx     <= '0;
         samp_lat   <= '0;
         samp_cnt   <= '0;
         bit_cnt    <= '0;
         sr         <= '0;
         res_data   <= '0;
         res_chan   <= '0;
      end else begin
         state      <= state_nxt;
         seq_init   <= (state_nxt == ST_INIT);
         seq_samp   <= (state_nxt == ST_SAMP);
         seq_comp   <= (state_nxt == ST_COMP);
         seq_update <= (state_nxt == ST_UPD);
         busy       <= (state_nxt != ST_IDLE);
         res_valid  <= (state_nxt == ST_OUT);

         if (state_nxt == ST_INIT) begin
            ch_idx   <= pick;
            ch_en    <= Nch'(1) << pick;
            samp_lat <= (samp_cycles == '0) ? SAMPW'(1) : samp_cycles;
            bit_cnt  <= '0;
            sr       <= '0;
         end else if (state_nxt == ST_OUT || state_nxt == ST_IDLE) begin
            ch_en <= '0;
         end

         if (state == ST_INIT)
            samp_cnt <= samp_lat - 1'b1;
         else if (state == ST_SAMP && samp_cnt != '0)
            samp_cnt <= samp_cnt - 1'b1;

         if (state == ST_UPD) begin
            sr      <= {sr[Madc-2:0], cur_bit};
            bit_cnt <= bit_cnt + 1'b1;
         end

         // Last decision goes straight into the output word; sr is free for the next conversion.
         if (state == ST_CAPT) begin
            res_data <= {sr[Madc-2:0], cur_bit};
            res_chan <= ch_idx;
         end
      end
   end

endmodule

// File: tb/tb_adc_seqctrl.sv
// Directed self-checking bench for adc_seqctrl (Madc=17, Nch=4).
module tb_adc_seqctrl;

   localparam int MADC  = 17;
   localparam int NCH   = 4;
   localparam int SAMPW = 8;
   localparam int CW    = 2;

   logic             clk = 1'b0;
   logic             rst, start, cont, res_ready;
   logic [NCH-1:0]   ch_mask, comp_out, ch_en;
   logic [SAMPW-1:0] samp_cycles;
   logic             seq_init, seq_samp, seq_comp, seq_update, busy, res_valid;
   logic [MADC-1:0]  res_data;
   logic [CW-1:0]    res_chan;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adc_seqctrl #(.Madc(MADC), .Nch(NCH), .SAMPW(SAMPW)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_mask(ch_mask),
      .samp_cycles(samp_cycles), .comp_out(comp_out),
      .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp),
      .seq_update(seq_update), .ch_en(ch_en), .busy(busy),
      .res_data(res_data), .res_chan(res_chan), .res_valid(res_valid),
      .res_ready(res_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start from IDLE; returns at the sample point of cycle 0 (INIT).
   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Expected {init,samp,comp,update} at cycle c for sample length s.
   function automatic logic [3:0] exp_strb(input int c, input int s);
      if (c == 0)                  return 4'b1000;
      if (c <= s)                  return 4'b0100;
      if (c <= s + 2 * MADC - 1)   return (((c - s - 1) % 2) == 0) ? 4'b0010 : 4'b0001;
      return 4'b0000;
   endfunction

   task automatic idle_chk(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_strb"}, 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'(0));
      chk({tag, "_valid"}, 32'(res_valid), 32'(0));
      chk({tag, "_chen"}, 32'(ch_en), 32'(0));
   endtask

   // Called at the sample point of cycle 0; returns at the sample point of the OUT cycle.
   // s is the effective sample length; start is pulsed during cycle start_at.
   task automatic conv(input string tag, input int chan, input int s,
                       input logic [MADC-1:0] pat, input int start_at);
      logic [NCH-1:0] oh;
      int last, k;
      logic b;
      oh   = NCH'(1) << chan;
      last = s + 2 * MADC + 1;
      for (int c = 0; c <= last; c++) begin
         chk({tag, "_strb"}, 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'(exp_strb(c, s)));
         chk({tag, "_busy"}, 32'(busy), 32'(1));
         chk({tag, "_chen"}, 32'(ch_en), (c < last) ? 32'(oh) : 32'(0));
         chk({tag, "_valid"}, 32'(res_valid), 32'(c == last));
         start = (c == start_at);
         if (c >= s + 2 && c < last && ((c - s - 2) % 2) == 0) begin
            k        = (c - s - 2) / 2;
            b        = pat[MADC - 1 - k];
            comp_out = b ? oh : ~oh;
         end else begin
            comp_out = NCH'($urandom);
         end
         if (c < last) step();
      end
      start = 1'b0;
      chk({tag, "_data"}, 32'(res_data), 32'(pat));
      chk({tag, "_chan"}, 32'(res_chan), 32'(chan));
   endtask

   localparam logic [MADC-1:0] P1 = 17'b10110011100101101;
   localparam logic [MADC-1:0] P2 = 17'b01001100011010010;
   localparam logic [MADC-1:0] P3 = 17'h0F0F1;
   localparam logic [MADC-1:0] P4 = 17'h1AAAA;
   localparam logic [MADC-1:0] P5 = 17'h05555;
   localparam logic [MADC-1:0] P6 = 17'h1FFFF;
   localparam logic [MADC-1:0] P7 = 17'h00001;
   localparam logic [MADC-1:0] P8 = 17'h13579;

   initial begin
      rst = 1'b1; start = 1'b0; cont = 1'b0; res_ready = 1'b1;
      ch_mask = '0; comp_out = '0; samp_cycles = '0;
      repeat (3) step();
      idle_chk("rst");
      chk("rst_data", 32'(res_data), 32'(0));
      chk("rst_chan", 32'(res_chan), 32'(0));
      rst = 1'b0;
      step();

      // Single shot, S=4: valid at cycle 39
      ch_mask = 4'b0001; samp_cycles = 8'd4;
      kick();
      conv("t1", 0, 4, P1, -1);
      step();
      idle_chk("t1_after");
      chk("t1_hold", 32'(res_data), 32'(P1));

      // samp_cycles=0 -> one sample cycle; a change after INIT is not seen
      samp_cycles = 8'd0;
      kick();
      samp_cycles = 8'd9;
      conv("t2", 0, 1, P2, -1);
      step();
      idle_chk("t2_after");

      // Empty mask ignores start
      ch_mask = 4'b0000;
      kick();
      for (int i = 0; i < 3; i++) begin
         idle_chk("t3_mask0");
         step();
      end

      // start during SAMP ignored, exactly one result
      ch_mask = 4'b0001; samp_cycles = 8'd3;
      kick();
      conv("t4", 0, 3, P3, 2);
      step();
      for (int i = 0; i < 4; i++) begin
         idle_chk("t4_after");
         step();
      end

      // Continuous round robin over 1010, then back-pressure, then cont drop
      ch_mask = 4'b1010; samp_cycles = 8'd2; cont = 1'b1;
      step();
      conv("t5a", 1, 2, P4, -1);
      step();
      conv("t5b", 3, 2, P5, -1);
      step();
      conv("t5c", 1, 2, P6, -1);
      step();
      res_ready = 1'b0;
      conv("t5d", 3, 2, P7, -1);
      for (int i = 0; i < 10; i++) begin
         chk("t5_bp_valid", 32'(res_valid), 32'(1));
         chk("t5_bp_data", 32'(res_data), 32'(P7));
         chk("t5_bp_chan", 32'(res_chan), 32'(3));
         chk("t5_bp_init", 32'(seq_init), 32'(0));
         if (i == 9) res_ready = 1'b1;
         step();
      end
      cont = 1'b0;
      conv("t5e", 1, 2, P8, -1);
      step();
      for (int i = 0; i < 3; i++) begin
         idle_chk("t5_after");
         step();
      end

      // Reset at the 5th COMP aborts; restart picks the lowest mask channel
      ch_mask = 4'b1100; samp_cycles = 8'd4;
      kick();
      repeat (4 + 9) step();
      chk("t6_5th_comp", 32'(seq_comp), 32'(1));
      rst = 1'b1;
      step();
      idle_chk("t6_rst");
      chk("t6_rst_data", 32'(res_data), 32'(0));
      rst = 1'b0;
      step();
      idle_chk("t6_idle");
      kick();
      conv("t6", 2, 4, P1, -1);
      step();
      idle_chk("t6_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
